// File: rtl/thermo_pkg.sv
// Shared types and constants for the thermometer-mask decoder.
package thermo_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_LANES = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Result field width: must be able to hold the value WIDTH itself.
    function automatic int unsigned idx_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/thermo_lane.sv
// Combinational per-chunk slice: popcount, lowest set bit, and gap/zero flags.
module thermo_lane
    import thermo_pkg::*;
#(
    parameter  int unsigned LANES = DEF_LANES,
    localparam int unsigned POP_W = $clog2(LANES + 1),
    localparam int unsigned OFF_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0] i_chunk,
    input  logic             i_seen_one,
    output logic [POP_W-1:0] o_popcnt,
    output logic [OFF_W-1:0] o_low_off,
    output logic             o_nonzero,
    output logic             o_gap,
    output logic             o_has_zero
);

    logic [LANES:0]   w_pre_one;
    logic [LANES-1:0] w_gap_bit;

    // w_pre_one[i] is set when any bit below position i is a one.
    assign w_pre_one[0] = 1'b0;

    for (genvar g = 0; g < LANES; g++) begin : g_bit
        assign w_pre_one[g+1] = w_pre_one[g] | i_chunk[g];
        assign w_gap_bit[g]   = ~i_chunk[g] & w_pre_one[g];
    end

    always_comb begin
        o_popcnt  = '0;
        o_low_off = '0;
        o_nonzero = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            o_popcnt = o_popcnt + POP_W'(i_chunk[i]);
            if (i_chunk[i] && !o_nonzero) begin
                o_low_off = OFF_W'(i);
                o_nonzero = 1'b1;
            end
        end
    end

    assign o_gap      = |w_gap_bit;
    // A zero anywhere breaks the code once a one has been seen in an earlier chunk.
    assign o_has_zero = i_seen_one & ~(&i_chunk);

endmodule

// File: rtl/thermo_decoder.sv
// Thermometer-mask decoder: recovers first-set index, popcount and well-formedness.
// Define THERMO_DECODER_ASSERT_EN to compile in protocol/result assertions.
module thermo_decoder
    import thermo_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned LANES = DEF_LANES,
    localparam int unsigned IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] out_count,
    output logic             out_thermo
);

    localparam int unsigned NCHUNK = WIDTH / LANES;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned POP_W  = $clog2(LANES + 1);
    localparam int unsigned OFF_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_chunk;
    logic [IDX_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_index;
    logic               r_seen;
    logic               r_broken;

    logic [POP_W-1:0]   w_pop;
    logic [OFF_W-1:0]   w_off;
    logic               w_nonzero;
    logic               w_gap;
    logic               w_has_zero;
    logic [IDX_W-1:0]   w_count_nxt;
    logic [IDX_W-1:0]   w_index_nxt;
    logic               w_seen_nxt;
    logic               w_broken_nxt;

    thermo_lane #(
        .LANES(LANES)
    ) u_lane (
        .i_chunk    (r_shift[LANES-1:0]),
        .i_seen_one (r_seen),
        .o_popcnt   (w_pop),
        .o_low_off  (w_off),
        .o_nonzero  (w_nonzero),
        .o_gap      (w_gap),
        .o_has_zero (w_has_zero)
    );

    always_comb begin
        w_count_nxt  = r_count + IDX_W'(w_pop);
        w_seen_nxt   = r_seen | w_nonzero;
        w_broken_nxt = r_broken | w_gap | w_has_zero;
        w_index_nxt  = r_index;
        if (!r_seen && w_nonzero) begin
            w_index_nxt = IDX_W'(r_chunk) * IDX_W'(LANES) + IDX_W'(w_off);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_chunk    <= '0;
            r_count    <= '0;
            r_index    <= '0;
            r_seen     <= 1'b0;
            r_broken   <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_count  <= '0;
            out_thermo <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift  <= in_data;
                        r_chunk  <= '0;
                        r_count  <= '0;
                        r_index  <= '0;
                        r_seen   <= 1'b0;
                        r_broken <= 1'b0;
                        in_ready <= 1'b0;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    r_shift  <= r_shift >> LANES;
                    r_chunk  <= r_chunk + CNT_W'(1);
                    r_count  <= w_count_nxt;
                    r_index  <= w_index_nxt;
                    r_seen   <= w_seen_nxt;
                    r_broken <= w_broken_nxt;
                    // Results are published from the next-state values of the final chunk.
                    if (r_chunk == LAST_CHUNK) begin
                        out_index  <= w_seen_nxt ? w_index_nxt : IDX_W'(WIDTH);
                        out_count  <= w_count_nxt;
                        out_thermo <= ~w_broken_nxt;
                        out_valid  <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef THERMO_DECODER_ASSERT_EN
    a_excl: assert property (@(posedge clk) disable iff (!reset_n)
        out_valid |-> !in_ready);
    a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
        out_valid |-> (32'(out_count) <= WIDTH));
    a_thermo_count: assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && out_thermo) |-> (32'(out_count) == WIDTH - 32'(out_index)));
    a_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_index)
                                       && $stable(out_count) && $stable(out_thermo)));
`endif

endmodule

// File: tb/tb_thermo_decoder.sv
// Directed self-checking bench for thermo_decoder (WIDTH=32, LANES=8).
module tb_thermo_decoder;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 8;
    localparam int unsigned IDX_W = 6;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [IDX_W-1:0] out_count;
    logic             out_thermo;

    int unsigned tests;
    int unsigned fails;

    thermo_decoder #(
        .WIDTH(WIDTH),
        .LANES(LANES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_count  (out_count),
        .out_thermo (out_thermo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word at a negedge; returns once the accepting edge has passed.
    task automatic send(input logic [31:0] d);
        int unsigned n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge after the accepting edge; counts edges until out_valid.
    task automatic await_result(input string tag, input logic [5:0] ei,
                                input logic [5:0] ec, input logic et);
        int unsigned n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 32'd4);
        chk({tag, "_index"}, 32'(out_index), 32'(ei));
        chk({tag, "_count"}, 32'(out_count), 32'(ec));
        chk({tag, "_thermo"}, 32'(out_thermo), 32'(et));
        chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic decode(input string tag, input logic [31:0] d, input logic [5:0] ei,
                          input logic [5:0] ec, input logic et);
        send(d);
        await_result(tag, ei, ec, et);
        release_result(tag);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_thermo", 32'(out_thermo), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        decode("ffffff00", 32'hFFFF_FF00, 6'd8,  6'd24, 1'b1);
        decode("7fffff00", 32'h7FFF_FF00, 6'd8,  6'd23, 1'b0);
        decode("zero",     32'h0000_0000, 6'd32, 6'd0,  1'b1);
        decode("ones",     32'hFFFF_FFFF, 6'd0,  6'd32, 1'b1);
        decode("00010001", 32'h0001_0001, 6'd0,  6'd2,  1'b0);
        decode("80000000", 32'h8000_0000, 6'd31, 6'd1,  1'b1);
        decode("0000f000", 32'h0000_F000, 6'd12, 6'd4,  1'b0);
        decode("fffffff8", 32'hFFFF_FFF8, 6'd3,  6'd29, 1'b1);

        // Backpressure: outputs hold and a new word is refused.
        send(32'hFFFF_FF00);
        await_result("bp", 6'd8, 6'd24, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_index", 32'(out_index), 32'd8);
            chk("bp_count", 32'(out_count), 32'd24);
            chk("bp_thermo", 32'(out_thermo), 32'd1);
        end
        in_valid = 1'b0;
        release_result("bp");

        // Reset during the second scan cycle aborts without emitting a result.
        send(32'hFFFF_0000);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_valid", 32'(out_valid), 32'd0);
        decode("post_rst", 32'hFFFF_FFF0, 6'd4, 6'd28, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
